// File: rtl/cdb_lane_arbiter_pkg.sv
// Shared definitions for the CDB lane arbiter slice.
//   FU_NUM             number of functional-unit completion requesters
//   CDB_LANES          number of CDB/complete lanes
//   SYS_FU_ADDR_WIDTH  width of an FU index on the complete path
//   FU_IDX_INVALID     lane_src value for a lane that carries nothing
//   onehot_to_idx()    one-hot FU vector to FU index (FU_IDX_INVALID if empty)
package cdb_lane_arbiter_pkg;

    localparam int FU_NUM            = 8;
    localparam int CDB_LANES         = 3;
    localparam int SYS_FU_ADDR_WIDTH = 4;

    typedef logic [SYS_FU_ADDR_WIDTH-1:0] fu_idx_t;

    // One valid bit per FU, index 7 = branch ... 0 = alu_1.
    typedef logic [FU_NUM-1:0] fu_state_packet_t;

    localparam fu_idx_t FU_IDX_INVALID = 4'hF;

    function automatic fu_idx_t onehot_to_idx(input fu_state_packet_t oh);
        fu_idx_t idx;
        idx = FU_IDX_INVALID;
        for (int i = 0; i < FU_NUM; i++) begin
            if (oh[i]) idx = fu_idx_t'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/cdb_lane_arbiter_if.sv
// FU-to-arbiter completion bus.
//   req_valid    FU -> arb  completed result waiting, one bit per FU
//   lane_en      ctl -> arb per-lane enable (lane 2 is first pick)
//   flush        ctl -> arb branch-mispredict squash
//   grant        arb -> FU  same-cycle grants
//   stall_mask   arb -> FU  same-cycle stalls
//   lane_valid   arb -> CS  registered lane occupancy
//   lane_src     arb -> CS  registered FU index per lane
//   urgent_mask  arb -> ctl registered starvation flags
interface cdb_lane_arbiter_if;
    import cdb_lane_arbiter_pkg::*;

    fu_state_packet_t                               req_valid;
    logic [CDB_LANES-1:0]                           lane_en;
    logic                                           flush;
    fu_state_packet_t                               grant;
    fu_state_packet_t                               stall_mask;
    logic [CDB_LANES-1:0]                           lane_valid;
    logic [CDB_LANES-1:0][SYS_FU_ADDR_WIDTH-1:0]    lane_src;
    fu_state_packet_t                               urgent_mask;

    modport master (
        output req_valid, lane_en, flush,
        input  grant, stall_mask, lane_valid, lane_src, urgent_mask
    );

    modport slave (
        input  req_valid, lane_en, flush,
        output grant, stall_mask, lane_valid, lane_src, urgent_mask
    );

endinterface

// File: rtl/cdb_lane_arbiter_rr_pick8.sv
// Round-robin single pick over 8 requesters.
//   req    request vector
//   start  index searched first; search ascends modulo 8
//   excl   requesters already taken by an earlier lane
//   pick   one-hot pick (0 when nothing eligible)
//   found  a pick was made
module cdb_lane_arbiter_rr_pick8 (
    input  logic [7:0] req,
    input  logic [2:0] start,
    input  logic [7:0] excl,
    output logic [7:0] pick,
    output logic       found
);

    always_comb begin : search
        logic [2:0] idx;
        pick  = '0;
        found = 1'b0;
        idx   = start;
        for (int i = 0; i < 8; i++) begin
            idx = start + 3'(i);
            if (!found && req[idx] && !excl[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_lane_arbiter.sv
// CDB lane arbiter: fills up to three CDB lanes from eight FU completion
// requesters each cycle. Priority is branch-first (optional), then starving
// requesters, then everyone else, round-robin within the last two classes.
//   clk  clock
//   rst  synchronous active-high reset
//   bus  cdb_lane_arbiter_if.slave (see interface header)
module cdb_lane_arbiter
    import cdb_lane_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = 8,
    parameter int NUM_LANES    = 3,
    parameter int STARVE_LIMIT = 4,
    parameter bit BRANCH_PRIO  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    cdb_lane_arbiter_if.slave bus
);

    localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

    logic [2:0]                 rr_ptr_q;
    logic [AGE_W-1:0]           age_q   [NUM_REQ];
    logic [AGE_W-1:0]           age_nxt [NUM_REQ];
    fu_state_packet_t           urgent_q;
    fu_state_packet_t           urgent_nxt;
    logic [CDB_LANES-1:0]       lane_valid_q;
    logic [CDB_LANES-1:0][SYS_FU_ADDR_WIDTH-1:0] lane_src_q;

    logic             active;
    fu_state_packet_t urg_req;
    logic             br_req;

    assign active  = !rst && !bus.flush;
    assign urg_req = urgent_q & bus.req_valid;
    assign br_req  = BRANCH_PRIO && bus.req_valid[7];

    // Lanes are served 2, 1, 0. Each lane excludes what the lanes above it
    // took, so a disabled lane simply passes its pick down the chain.
    fu_state_packet_t excl_2, excl_1, excl_0;
    fu_state_packet_t u_pick_2, u_pick_1, u_pick_0;
    fu_state_packet_t n_pick_2, n_pick_1, n_pick_0;
    logic             u_fnd_2, u_fnd_1, u_fnd_0;
    logic             n_fnd_2, n_fnd_1, n_fnd_0;
    fu_state_packet_t g_2, g_1, g_0;

    cdb_lane_arbiter_rr_pick8 u_urg_2 (.req(urg_req),       .start(rr_ptr_q), .excl(excl_2), .pick(u_pick_2), .found(u_fnd_2));
    cdb_lane_arbiter_rr_pick8 u_nrm_2 (.req(bus.req_valid), .start(rr_ptr_q), .excl(excl_2), .pick(n_pick_2), .found(n_fnd_2));
    cdb_lane_arbiter_rr_pick8 u_urg_1 (.req(urg_req),       .start(rr_ptr_q), .excl(excl_1), .pick(u_pick_1), .found(u_fnd_1));
    cdb_lane_arbiter_rr_pick8 u_nrm_1 (.req(bus.req_valid), .start(rr_ptr_q), .excl(excl_1), .pick(n_pick_1), .found(n_fnd_1));
    cdb_lane_arbiter_rr_pick8 u_urg_0 (.req(urg_req),       .start(rr_ptr_q), .excl(excl_0), .pick(u_pick_0), .found(u_fnd_0));
    cdb_lane_arbiter_rr_pick8 u_nrm_0 (.req(bus.req_valid), .start(rr_ptr_q), .excl(excl_0), .pick(n_pick_0), .found(n_fnd_0));

    function automatic fu_state_packet_t lane_pick(
        input logic             en,
        input logic             br,
        input fu_state_packet_t excl,
        input logic             u_fnd,
        input fu_state_packet_t u_pick,
        input logic             n_fnd,
        input fu_state_packet_t n_pick
    );
        fu_state_packet_t p;
        p = '0;
        if (en) begin
            if (br && !excl[7]) p = 8'h80;
            else if (u_fnd)     p = u_pick;
            else if (n_fnd)     p = n_pick;
        end
        return p;
    endfunction

    assign excl_2 = '0;
    assign g_2    = lane_pick(active && bus.lane_en[2], br_req, excl_2, u_fnd_2, u_pick_2, n_fnd_2, n_pick_2);
    assign excl_1 = g_2;
    assign g_1    = lane_pick(active && bus.lane_en[1], br_req, excl_1, u_fnd_1, u_pick_1, n_fnd_1, n_pick_1);
    assign excl_0 = g_2 | g_1;
    assign g_0    = lane_pick(active && bus.lane_en[0], br_req, excl_0, u_fnd_0, u_pick_0, n_fnd_0, n_pick_0);

    fu_state_packet_t grant;
    assign grant          = g_2 | g_1 | g_0;
    assign bus.grant      = grant;
    assign bus.stall_mask = active ? (bus.req_valid & ~grant) : '0;

    // Pointer follows the lowest-numbered lane that was granted.
    logic [2:0] rr_nxt;
    always_comb begin
        rr_nxt = rr_ptr_q;
        if (g_0 != '0)      rr_nxt = 3'(onehot_to_idx(g_0)) + 3'd1;
        else if (g_1 != '0) rr_nxt = 3'(onehot_to_idx(g_1)) + 3'd1;
        else if (g_2 != '0) rr_nxt = 3'(onehot_to_idx(g_2)) + 3'd1;
    end

    always_comb begin
        urgent_nxt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            age_nxt[i] = '0;
            if (bus.req_valid[i] && !grant[i]) begin
                age_nxt[i] = (age_q[i] == AGE_MAX) ? age_q[i] : age_q[i] + AGE_W'(1);
            end
            urgent_nxt[i] = (age_nxt[i] >= AGE_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            rr_ptr_q     <= '0;
            urgent_q     <= '0;
            lane_valid_q <= '0;
            for (int l = 0; l < NUM_LANES; l++) lane_src_q[l] <= FU_IDX_INVALID;
            for (int i = 0; i < NUM_REQ; i++)   age_q[i]      <= '0;
        end else begin
            rr_ptr_q     <= rr_nxt;
            urgent_q     <= urgent_nxt;
            lane_valid_q <= {g_2 != '0, g_1 != '0, g_0 != '0};
            lane_src_q[2] <= onehot_to_idx(g_2);
            lane_src_q[1] <= onehot_to_idx(g_1);
            lane_src_q[0] <= onehot_to_idx(g_0);
            for (int i = 0; i < NUM_REQ; i++) age_q[i] <= age_nxt[i];
        end
    end

    assign bus.lane_valid  = lane_valid_q;
    assign bus.lane_src    = lane_src_q;
    assign bus.urgent_mask = urgent_q;

endmodule
